microcode_sequencer: RTL
========================

# microcode_sequencer

Control sequencer for the 8-bit bus CPU. It steps a 5-state microstep counter (T0–T4) and decodes the current microstep and the 4-bit instruction-register opcode into the one-hot control lines that drive the PC, memory, A/B registers, ALU, output register and flags. It samples the ALU carry/zero flags for conditional jumps and implements a sticky halt.

## Interface
Parameters: none.

Ports. All controls are active-high. The clock and reset are one clock, `clk`, and a synchronous, active-high reset, `rst`.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  4  instruction register upper nibble; valid from T2
- carry  in  1  ALU registered carry flag
- zero  in  1  ALU registered zero flag
- step  out  3  current microstep, 0..4
- halt  out  1  CPU halted (sticky)
- pc_out  out  1  PC drives bus
- pc_enable  out  1  PC increments
- jump  out  1  PC loads from bus
- mem_addr_in  out  1  memory address register loads
- ram_in  out  1  RAM writes from bus
- ram_out  out  1  RAM drives bus
- instr_in  out  1  instruction register loads
- instr_out  out  1  instruction register operand nibble drives bus
- a_in  out  1  A register loads
- a_out  out  1  A register drives bus
- b_in  out  1  B register loads
- alu_out  out  1  ALU drives bus
- subtract  out  1  ALU subtract select
- flags_in  out  1  ALU flag registers load
- out_in  out  1  output register loads

## Operation
- State is a 3-bit `step` register and a 1-bit `halted` register. All control outputs decode combinationally from the state, `opcode`, `carry` and `zero`. They are Moore-style within a microstep.
- Step sequence: 0→1→2→3→4→0. Every instruction takes exactly 5 cycles. There is no early termination.
- Fetch, all opcodes:
  - T0: pc_out, mem_addr_in.
  - T1: ram_out, instr_in, pc_enable.
- Execute, listed by opcode. Steps not listed assert nothing.
  - 0000 NOP: none.
  - 0001 LDA: T2 instr_out, mem_addr_in. T3 ram_out, a_in.
  - 0010 ADD: T2 instr_out, mem_addr_in. T3 ram_out, b_in. T4 alu_out, a_in, flags_in.
  - 0011 SUB: same as ADD, plus subtract asserted in T3 and T4. T3 ensures the ALU has settled.
  - 0100 STA: T2 instr_out, mem_addr_in. T3 a_out, ram_in.
  - 0101 LDI: T2 instr_out, a_in.
  - 0110 JMP: T2 instr_out, jump.
  - 0111 JC / 1000 JZ: see Configuration.
  - 1110 OUT: T2 a_out, out_in.
  - 1111 HLT: T2 halt. `halted` sets on the T2 rising edge.
  - 1001–1101 (undefined): behave as NOP.
- Halted state: `step` frozen at 2, `halt`=1, every other control 0. It is left only via `rst`.
- Bus exclusivity: at most one of pc_out, ram_out, instr_out, a_out, alu_out is 1 in any cycle.

## Timing
- Reset: when `rst` is high at a rising edge, step←0 and halted←0. This holds in any step, including mid-instruction and while halted.
- While `rst` is high, all control outputs are forced to 0 combinationally, and `halt` is forced to 0 as well. After the edge with `rst` low, T0 controls appear.
- Output reset values: step=0, halt=0, all controls 0.
- Latency: control lines are valid for the full microstep cycle. Register loads they enable take effect at the rising edge that ends the step.
- `opcode` is loaded at the end of T1, so it is first used in T2.
- Flags are read combinationally during T2 of JC/JZ. The flags from a preceding ADD/SUB were written at that instruction's T4 edge, so they are stable.
- The `step` wrap from 4 to 0 is unconditional. `halted` blocks every step increment.

## Configuration
- Macro: `MICROCODE_SEQUENCER_COND_JUMP_EN`.
- Defined:
  - JC (0111), T2: instr_out and jump are asserted only if carry=1. Otherwise nothing is asserted.
  - JZ (1000), T2: the same, gated by zero=1.
- Undefined: 0111 and 1000 decode as NOP, and the carry/zero inputs are unused.

## Test plan
- Reset then fetch: rst=1 for 2 cycles, then 0.
  - Expect step=0 and all outputs 0 during reset.
  - T0: pc_out=1, mem_addr_in=1.
  - T1: ram_out=1, instr_in=1, pc_enable=1.
- SUB 0011, with opcode driven from T2:
  - T2: instr_out, mem_addr_in.
  - T3: ram_out, b_in, subtract.
  - T4: alu_out, a_in, flags_in, subtract.
  - Next cycle: step=0.
- JC/JZ, with the macro defined:
  - JC with carry=0: T2 all controls 0.
  - JC with carry=1: T2 instr_out=1, jump=1.
  - JZ with zero=1: T2 jump=1.
  - Without the macro: JZ with zero=1 gives jump=0.
- HLT 1111: halt=1 from T2 onward, with step=2 held for 10 cycles and no other controls. rst=1 then gives step=0, halt=0.
- Reset mid-instruction: during ADD T3, rst=1 forces all controls 0 that cycle and gives step=0 on the next cycle.
- Undefined opcode 1011: T2–T4 all controls 0, and the fetch of the next instruction follows normally.

Source files
------------

// File: rtl/microcode_sequencer_if.sv
// rtl/microcode_sequencer_if.sv - opcode/flag inputs and control lines between the sequencer and the datapath
interface microcode_sequencer_if;
  logic [3:0] opcode;
  logic       carry;
  logic       zero;
  logic [2:0] step;
  logic       halt;
  logic       pc_out;
  logic       pc_enable;
  logic       jump;
  logic       mem_addr_in;
  logic       ram_in;
  logic       ram_out;
  logic       instr_in;
  logic       instr_out;
  logic       a_in;
  logic       a_out;
  logic       b_in;
  logic       alu_out;
  logic       subtract;
  logic       flags_in;
  logic       out_in;

  modport master (
    input  opcode, carry, zero,
    output step, halt, pc_out, pc_enable, jump, mem_addr_in, ram_in, ram_out,
           instr_in, instr_out, a_in, a_out, b_in, alu_out, subtract, flags_in, out_in
  );

  modport slave (
    output opcode, carry, zero,
    input  step, halt, pc_out, pc_enable, jump, mem_addr_in, ram_in, ram_out,
           instr_in, instr_out, a_in, a_out, b_in, alu_out, subtract, flags_in, out_in
  );
endinterface

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - T0..T4 microstep sequencer and control decode; MICROCODE_SEQUENCER_COND_JUMP_EN enables JC/JZ
module microcode_sequencer (
  input  logic                  clk,
  input  logic                  rst,
  microcode_sequencer_if.master bus
);
  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  step_t step_q;
  logic  halted_q;
  logic  hlt_now;

  assign hlt_now = (step_q == T2) && (bus.opcode == OP_HLT);

  // HLT parks the counter at T2 instead of advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      if (hlt_now) begin
        halted_q <= 1'b1;
      end else begin
        case (step_q)
          T0:      step_q <= T1;
          T1:      step_q <= T2;
          T2:      step_q <= T3;
          T3:      step_q <= T4;
          default: step_q <= T0;
        endcase
      end
    end
  end

`ifndef MICROCODE_SEQUENCER_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = bus.carry ^ bus.zero;
`endif

  // Only one bus driver per step: pc_out, ram_out, instr_out, a_out, alu_out.
  always_comb begin
    bus.pc_out      = 1'b0;
    bus.pc_enable   = 1'b0;
    bus.jump        = 1'b0;
    bus.mem_addr_in = 1'b0;
    bus.ram_in      = 1'b0;
    bus.ram_out     = 1'b0;
    bus.instr_in    = 1'b0;
    bus.instr_out   = 1'b0;
    bus.a_in        = 1'b0;
    bus.a_out       = 1'b0;
    bus.b_in        = 1'b0;
    bus.alu_out     = 1'b0;
    bus.subtract    = 1'b0;
    bus.flags_in    = 1'b0;
    bus.out_in      = 1'b0;
    if (!rst && !halted_q) begin
      case (step_q)
        T0: begin
          bus.pc_out      = 1'b1;
          bus.mem_addr_in = 1'b1;
        end
        T1: begin
          bus.ram_out   = 1'b1;
          bus.instr_in  = 1'b1;
          bus.pc_enable = 1'b1;
        end
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus.instr_out   = 1'b1;
              bus.mem_addr_in = 1'b1;
            end
            OP_LDI: begin
              bus.instr_out = 1'b1;
              bus.a_in      = 1'b1;
            end
            OP_JMP: begin
              bus.instr_out = 1'b1;
              bus.jump      = 1'b1;
            end
`ifdef MICROCODE_SEQUENCER_COND_JUMP_EN
            OP_JC: begin
              bus.instr_out = bus.carry;
              bus.jump      = bus.carry;
            end
            OP_JZ: begin
              bus.instr_out = bus.zero;
              bus.jump      = bus.zero;
            end
`endif
            OP_OUT: begin
              bus.a_out  = 1'b1;
              bus.out_in = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (bus.opcode)
            OP_LDA: begin
              bus.ram_out = 1'b1;
              bus.a_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.ram_out  = 1'b1;
              bus.b_in     = 1'b1;
              bus.subtract = (bus.opcode == OP_SUB);
            end
            OP_STA: begin
              bus.a_out  = 1'b1;
              bus.ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.alu_out  = 1'b1;
            bus.a_in     = 1'b1;
            bus.flags_in = 1'b1;
            bus.subtract = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.step = step_q;
  assign bus.halt = !rst && (halted_q || hlt_now);
endmodule
